// File: rtl/bin_to_bcd_seq_if.sv
// Start/done handshake bundle between a requester and the sequential binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      din;
  logic                  busy;
  logic                  done;
  logic                  neg;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, din, input busy, done, neg, bcd);
  modport slave  (input start, din, output busy, done, neg, bcd);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: shift-and-add-3, one input bit per clock,
// sign/magnitude output for the calculator result path.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [BW-1:0]    scr_q, scr_d;
  logic [BW-1:0]    adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             neg_q, neg_d;
  logic [BW-1:0]    bcd_q, bcd_d;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    neg_d   = neg_q;
    bcd_d   = bcd_q;

    // Add-3 correction keeps each nibble a valid decimal digit after the doubling shift.
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sign_d  = SIGNED && bus.din[WIDTH-1];
          mag_d   = sign_d ? -bus.din : bus.din;
          scr_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {scr_d, mag_d} = {adj, mag_q} << 1;
        cnt_d          = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d   = scr_q;
        neg_d   = sign_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      neg_q   <= neg_d;
      bcd_q   <= bcd_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.neg  = neg_q;
  assign bus.bcd  = bcd_q;

endmodule
